// File: rtl/cv32e40s_obi_data_responder.sv
// ---------------------------------------------------------------------------
// cv32e40s_obi_data_responder
//
// This is the responder end of the OBI data interface driven by the LSU.
// Granted requests access a single-port word memory. Responses come back in
// order through a DEPTH-entry response FIFO. Two test-side stall inputs
// throttle grant timing and response timing.
//
// Handshake semantics:
//   - A request is accepted in a cycle where req_i && gnt_o.
//   - A response is delivered in a cycle where rvalid_o is high.
//   - There is no response ready signal. The requester must consume the
//     response in the same cycle that rvalid_o is high.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req_i, gnt_o      request valid / grant
//   addr_i            byte address; word index = addr_i[31:2]
//   we_i, be_i        store enable / byte enables
//   wdata_i           store data
//   memtype_i         memory type; accepted and ignored
//   rvalid_o          response valid
//   rdata_o, err_o    load data and bus error of the head response
//                     (both are 0 when rvalid_o is low)
//   gnt_stall_i       forces gnt_o low
//   rvalid_stall_i    holds the FIFO head and forces rvalid_o low
//   busy_o            responses pending, or a request present
// ---------------------------------------------------------------------------
module cv32e40s_obi_data_responder #(
    parameter int DEPTH     = 2,
    parameter int MEM_WORDS = 1024,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  memtype_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        gnt_stall_i,
    input  logic        rvalid_stall_i,
    output logic        busy_o
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]          mem [MEM_WORDS];
    logic [31:0]          fifo_rdata [DEPTH];
    logic                 fifo_err [DEPTH];
    logic [PTR_W-1:0]     wptr_q;
    logic [PTR_W-1:0]     rptr_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic [31:0]          word_idx;
    logic [MEM_AW-1:0]    mem_idx;
    logic                 in_range;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [31:0]          push_rdata;
    logic                 push_err;
    logic                 unused_ok;

    // The memory type and the byte offset within the word play no role.
    assign unused_ok = ^{memtype_i, addr_i[1:0]};

    assign word_idx = {2'b00, addr_i[31:2]};
    assign in_range = word_idx < 32'(MEM_WORDS);
    assign mem_idx  = word_idx[MEM_AW-1:0];

    // The grant ignores any pop in the same cycle, so a full FIFO never grants.
    assign gnt_o  = req_i && !gnt_stall_i && (cnt_q < CNT_WIDTH'(DEPTH));
    assign accept = req_i && gnt_o;
    // No push takes place while rst is high. A store accepted in that cycle
    // still reaches memory (see the memory block below).
    assign push   = accept && !rst;
    assign pop    = (cnt_q != '0) && !rvalid_stall_i;

    // A load captures the word as it is before this edge. Stores and
    // out-of-range accesses return zero data.
    assign push_rdata = (!we_i && in_range) ? mem[mem_idx] : 32'h0;
    assign push_err   = !in_range;

    assign rvalid_o = pop;
    assign rdata_o  = pop ? fifo_rdata[rptr_q] : 32'h0;
    assign err_o    = pop ? fifo_err[rptr_q] : 1'b0;
    assign busy_o   = (cnt_q != '0) || req_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Memory contents are not reset.
    always_ff @(posedge clk) begin
        if (accept && we_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[mem_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rdata[wptr_q] <= push_rdata;
            fifo_err[wptr_q]   <= push_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            // A push and a pop in the same cycle leave cnt_q unchanged.
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end else if (!push && pop) begin
                cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cv32e40s_obi_data_responder.sv
module tb_cv32e40s_obi_data_responder;

    localparam int DEPTH     = 2;
    localparam int MEM_WORDS = 1024;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic [1:0]  memtype_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        gnt_stall_i;
    logic        rvalid_stall_i;
    logic        busy_o;

    always #5 clk = ~clk;

    cv32e40s_obi_data_responder #(
        .DEPTH(DEPTH),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_i(req_i),
        .gnt_o(gnt_o),
        .addr_i(addr_i),
        .we_i(we_i),
        .be_i(be_i),
        .wdata_i(wdata_i),
        .memtype_i(memtype_i),
        .rvalid_o(rvalid_o),
        .rdata_o(rdata_o),
        .err_o(err_o),
        .gnt_stall_i(gnt_stall_i),
        .rvalid_stall_i(rvalid_stall_i),
        .busy_o(busy_o)
    );

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rq, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input logic gs, input logic rs);
        rst            = r;
        req_i          = rq;
        we_i           = w;
        addr_i         = a;
        be_i           = b;
        wdata_i        = d;
        gnt_stall_i    = gs;
        rvalid_stall_i = rs;
        memtype_i      = 2'($urandom_range(0, 3));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        gs;
        logic        rs;
        logic        e_gnt;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_err;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rq, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic gs, input logic rs,
                       input logic g, input logic v, input logic [31:0] rd, input logic e,
                       input logic bz);
        vec_t x;
        x.r = r; x.req = rq; x.we = w; x.addr = a; x.be = b; x.wd = d; x.gs = gs; x.rs = rs;
        x.e_gnt = g; x.e_rv = v; x.e_rd = rd; x.e_err = e; x.e_busy = bz;
        vecs.push_back(x);
    endtask

    task automatic idle(input logic v, input logic [31:0] rd, input logic e, input logic bz);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, v, rd, e, bz);
    endtask

    task automatic fill_table();
        // reset and idle
        add(1, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0,                     0, 0, 0, 0, 0);
        // byte-lane write and readback (first row also: grant right after reset)
        add(0, 1, 1, 32'h10, 4'hF, 32'hAABBCCDD, 0, 0,  1, 0, 0, 0, 1);
        add(0, 1, 1, 32'h10, 4'h5, 32'h11223344, 0, 0,  1, 1, 0, 0, 1);
        add(0, 1, 0, 32'h10, 4'h0, 0, 0, 0,             1, 1, 0, 0, 1);
        idle(1, 32'hAA22CC44, 0, 1);
        idle(0, 0, 0, 0);
        // out of range
        add(0, 1, 1, 32'hFFC, 4'hF, 32'h5A5A0FFC, 0, 0,  1, 0, 0, 0, 1);
        add(0, 1, 1, 32'h1000, 4'hF, 32'hDEADBEEF, 0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 0, 32'h1000, 4'h0, 0, 0, 0,            1, 1, 0, 1, 1);
        add(0, 1, 0, 32'hFFC, 4'h0, 0, 0, 0,             1, 1, 0, 1, 1);
        idle(1, 32'h5A5A0FFC, 0, 1);
        idle(0, 0, 0, 0);
        // preload words for the FIFO test
        add(0, 1, 1, 32'h20, 4'hF, 32'hC0DE0000, 0, 0,  1, 0, 0, 0, 1);
        add(0, 1, 1, 32'h24, 4'hF, 32'hC0DE0001, 0, 0,  1, 1, 0, 0, 1);
        add(0, 1, 1, 32'h28, 4'hF, 32'hC0DE0002, 0, 0,  1, 1, 0, 0, 1);
        add(0, 1, 1, 32'h2C, 4'hF, 32'hC0DE0003, 0, 0,  1, 1, 0, 0, 1);
        idle(1, 0, 0, 1);
        idle(0, 0, 0, 0);
        // FIFO full under rvalid stall, then drain with wrap
        add(0, 1, 0, 32'h20, 0, 0, 0, 1,  1, 0, 0, 0, 1);
        add(0, 1, 0, 32'h24, 0, 0, 0, 1,  1, 0, 0, 0, 1);
        add(0, 1, 0, 32'h28, 0, 0, 0, 1,  0, 0, 0, 0, 1);
        add(0, 1, 0, 32'h28, 0, 0, 0, 1,  0, 0, 0, 0, 1);
        add(0, 1, 0, 32'h28, 0, 0, 0, 0,  0, 1, 32'hC0DE0000, 0, 1);
        add(0, 1, 0, 32'h28, 0, 0, 0, 0,  1, 1, 32'hC0DE0001, 0, 1);
        add(0, 1, 0, 32'h2C, 0, 0, 0, 0,  1, 1, 32'hC0DE0002, 0, 1);
        idle(1, 32'hC0DE0003, 0, 1);
        idle(0, 0, 0, 0);
        // grant stall
        for (int i = 0; i < 3; i++) add(0, 1, 0, 32'h20, 0, 0, 1, 0,  0, 0, 0, 0, 1);
        add(0, 1, 0, 32'h20, 0, 0, 0, 0,  1, 0, 0, 0, 1);
        idle(1, 32'hC0DE0000, 0, 1);
        idle(0, 0, 0, 0);
        // reset with two responses pending under stall
        add(0, 1, 0, 32'h24, 0, 0, 0, 1,  1, 0, 0, 0, 1);
        add(0, 1, 0, 32'h28, 0, 0, 0, 1,  1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1,       0, 0, 0, 0, 1);
        idle(0, 0, 0, 0);
        idle(0, 0, 0, 0);
        add(0, 1, 0, 32'h2C, 0, 0, 0, 0,  1, 0, 0, 0, 1);
        idle(1, 32'hC0DE0003, 0, 1);
        idle(0, 0, 0, 0);
        // store accepted during reset is written, but no response is pushed
        add(1, 1, 1, 32'h30, 4'hF, 32'h600DF00D, 0, 0,  1, 0, 0, 0, 1);
        add(0, 1, 0, 32'h30, 0, 0, 0, 0,                1, 0, 0, 0, 1);
        idle(1, 32'h600DF00D, 0, 1);
        idle(0, 0, 0, 0);
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Entry layout: {data_known, err, rdata}.
    logic [33:0] exp_q[$];
    logic [31:0] ref_mem [int];

    // One cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic model_cycle(input logic r, input logic rq, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] d, input logic gs,
                               input logic rs, output logic granted);
        logic        e_gnt;
        logic        e_pop;
        logic [33:0] head;
        int          idx;
        logic [31:0] word;
        drive(r, rq, w, a, b, d, gs, rs);
        @(negedge clk);
        e_gnt = rq && !gs && (exp_q.size() < DEPTH);
        e_pop = (exp_q.size() != 0) && !rs;
        head  = e_pop ? exp_q[0] : 34'h2_0000_0000;
        check("rnd gnt", 32'(gnt_o), 32'(e_gnt));
        check("rnd rvalid", 32'(rvalid_o), 32'(e_pop));
        check("rnd err", 32'(err_o), 32'(head[32]));
        if (head[33]) check("rnd rdata", rdata_o, head[31:0]);
        check("rnd busy", 32'(busy_o), 32'((exp_q.size() != 0) || rq));
        if (e_pop) void'(exp_q.pop_front());
        if (e_gnt) begin
            idx = int'(a >> 2);
            if (a >= 32'(MEM_WORDS * 4)) begin
                if (!r) exp_q.push_back({1'b1, 1'b1, 32'h0});
            end else if (w) begin
                word = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
                for (int k = 0; k < 4; k++) if (b[k]) word[8*k +: 8] = d[8*k +: 8];
                // Partial writes to a never-written word leave other lanes unknown,
                // so only full-word writes make a word known.
                if (ref_mem.exists(idx) || b == 4'hF) ref_mem[idx] = word;
                if (!r) exp_q.push_back({1'b1, 1'b0, 32'h0});
            end else begin
                if (!r) exp_q.push_back({ref_mem.exists(idx), 1'b0,
                                         ref_mem.exists(idx) ? ref_mem[idx] : 32'h0});
            end
        end
        if (r) exp_q.delete();
        granted = e_gnt;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        if ($urandom_range(0, 9) < 8) begin
            k = $urandom_range(0, 23);
            k = (k < 16) ? k : (1000 + k);
            return (32'(k) << 2) | 32'($urandom_range(0, 3));
        end
        return 32'h0000_1000 + ($urandom() & 32'h7FFF_FFFF);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic g;
        int   tries;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        fill_table();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].be,
                  vecs[i].wd, vecs[i].gs, vecs[i].rs);
            @(negedge clk);
            check($sformatf("row%0d gnt", i), 32'(gnt_o), 32'(vecs[i].e_gnt));
            check($sformatf("row%0d rvalid", i), 32'(rvalid_o), 32'(vecs[i].e_rv));
            check($sformatf("row%0d rdata", i), rdata_o, vecs[i].e_rd);
            check($sformatf("row%0d err", i), 32'(err_o), 32'(vecs[i].e_err));
            check($sformatf("row%0d busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
            @(posedge clk);
            #1;
        end

        // Preload every in-range word the random phase touches.
        for (int k = 0; k < 24; k++) begin
            int w;
            w = (k < 16) ? k : (1000 + k);
            tries = 0;
            g = 1'b0;
            while (!g && tries < 20) begin
                model_cycle(0, 1, 1, 32'(w) << 2, 4'hF, $urandom(), 0, 0, g);
                tries++;
            end
            check("preload grant", 32'(g), 32'(1));
        end

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            model_cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 1) == 1, rand_addr(), 4'($urandom_range(0, 15)),
                        $urandom(), $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, g);
        end

        // Drain remaining responses.
        tries = 0;
        while (exp_q.size() != 0 && tries < 10) begin
            model_cycle(0, 0, 0, 0, 0, 0, 0, 0, g);
            tries++;
        end
        check("drain empty", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed",
                 tests, failed);
        $fatal(1, "watchdog");
    end

endmodule
